mk_design_arb_05: RTL and testbench
===================================

MK_DESIGN_ARB_05 -- requirements
Module: mkDesignArb_05

Interface
REQ-001 SHALL have parameter: W, 9, operand/result width.
REQ-002 SHALL have parameter: TMO, 255, watchdog limit in cycles (used only with ARB_TIMEOUT_EN).
REQ-003 SHALL have port: CLK  in  1  single clock, all state rising-edge.
REQ-004 SHALL have port: RST  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: reqN_start_a, reqN_start_b, reqN_start_c  in  W each  operands, for N=0,1.
REQ-006 SHALL have port: EN_reqN_start  in  1  start request; RDY_reqN_start  out  1  start acceptable.
REQ-007 SHALL have port: reqN_result  out  W  result; RDY_reqN_result  out  1  result valid; EN_reqN_result  in  1  result taken.
REQ-008 SHALL have port: reqN_err  out  1  timeout flag qualifying reqN_result.
REQ-009 SHALL have port: dsn_start_a, dsn_start_b  out  W  operands; dsn_st_enable  out  1  start fire; dsn_RDY_start  in  1.
REQ-010 SHALL have port: dsn_result_c  out  W  result argument; dsn_result  in  W; dsn_RDY_result  in  1.

Function
REQ-011 SHALL implement FSM IDLE, ISSUE, WAIT, DELIVER; one transaction outstanding at a time.
REQ-012 SHALL assert RDY_reqN_start for both N only in IDLE.
REQ-013 SHALL accept a start when EN_reqN_start and RDY_reqN_start: latch a, b, c, owner; IDLE->ISSUE.
REQ-014 SHALL, if both EN_req0_start and EN_req1_start are high in IDLE, grant the requester indicated by the priority pointer; the loser is not accepted and retries.
REQ-015 SHALL, in ISSUE, drive latched a/b on dsn_start_a/b and assert dsn_st_enable exactly one cycle, the first cycle dsn_RDY_start=1; then ->WAIT.
REQ-016 SHALL drive latched c on dsn_result_c in ISSUE and WAIT; 0 otherwise.
REQ-017 SHALL, in WAIT, capture dsn_result on the first cycle dsn_RDY_result=1; ->DELIVER.
REQ-018 SHALL, in DELIVER, assert RDY_reqN_result and drive reqN_result only for the owner; other requester's result outputs stay 0.
REQ-019 SHALL, on EN_reqN_result from the owner in DELIVER, go ->IDLE and set the priority pointer to the non-owner; EN from a non-owner is ignored.
REQ-020 SHALL hold minimum latency: accept at cycle 0, dsn_st_enable at cycle 1, result capture at cycle 2 or later, RDY_reqN_result the cycle after capture.
REQ-021 SHALL ignore EN_reqN_start outside IDLE and dsn_RDY_result outside WAIT.

Reset
REQ-022 SHALL, on RST high, immediately force state IDLE, priority pointer 0, latched data 0, all outputs 0 except RDY_reqN_start, which is 1 after reset release.
REQ-023 SHALL abandon any transaction in progress on reset; no dsn_st_enable and no RDY_reqN_result for it.

Configuration
REQ-024 SHALL, with ARB_TIMEOUT_EN defined, count cycles in ISSUE+WAIT; on reaching TMO, go ->DELIVER with reqN_result=0 and reqN_err=1 for the owner.
REQ-025 SHALL, without ARB_TIMEOUT_EN, have no counter; the FSM waits indefinitely and reqN_err is tied 0.

Structure
REQ-026 SHALL place the state enum, the default width constant and the default TMO in package mk_design_arb_pkg.
REQ-027 SHALL use one sub-module, arb_rr2 (two-way round-robin grant with pointer update input).

Verification
REQ-028 SHALL cover a single request: req0 a=3, b=5, c=7, dsn_RDY_result at cycle 3 with dsn_result=0x1F -> dsn_st_enable at cycle 1 with a=3, b=5; dsn_result_c=7; req0_result=0x1F at cycle 4.
REQ-029 SHALL cover simultaneous requests after reset: req0 granted first; after its EN_req0_result, the same-cycle retry by req1 is granted before req0's next request.
REQ-030 SHALL cover backpressure: dsn_RDY_start low for 4 cycles -> dsn_st_enable exactly once, on the 5th ISSUE cycle.
REQ-031 SHALL cover reset mid-WAIT: assert RST -> next cycle IDLE, RDY_req0/1_start=1 after release, no stale result.
REQ-032 SHALL cover, with ARB_TIMEOUT_EN and TMO=8, dsn_RDY_result never asserted -> owner gets RDY_reqN_result with reqN_err=1, result 0.
REQ-033 SHALL cover all-ones operands 0x1FF -> passed unaltered on 9-bit ports; a non-owner EN_reqN_result is ignored.

Source files
------------

// File: rtl/mk_design_arb_pkg.sv
// Shared types and default constants for the two-requester design arbiter.
package mk_design_arb_pkg;

  // Default operand/result width.
  localparam int ARB_W = 9;

  // Default watchdog limit in cycles, used only when the timeout is built in.
  localparam int ARB_TMO = 255;

  // One transaction is outstanding at a time; this walks it through the design.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mk_design_arb_05_arb_rr2.sv
// arb_rr2: two-way round-robin grant. The pointer names the requester that
// wins a tie; the owner of a finished transaction hands priority to the
// other side through the update input.
module arb_rr2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_owner_i,
  output logic [1:0] grant_o
);

  logic ptr_q;
  logic ptr_d;

  // Next pointer: the non-owner of the completed transaction.
  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) begin
      ptr_d = ~upd_owner_i;
    end
  end

  // Pointer register, cleared to favour requester 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // A lone request wins outright; a tie goes to the pointed-at requester.
  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = ptr_q ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mk_design_arb_05.sv
// mk_design_arb_05: shares one start/result design between two requesters.
// A start is latched in IDLE, fired once into the design in ISSUE, its result
// is captured in WAIT and handed to the owning requester in DELIVER.
// Optional build macro ARB_TIMEOUT_EN adds a watchdog over ISSUE+WAIT that
// delivers a zero result flagged with reqN_err after TMO cycles.
module mk_design_arb_05
  import mk_design_arb_pkg::*;
#(
  parameter int W   = ARB_W,
  parameter int TMO = ARB_TMO
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] req0_start_a,
  input  logic [W-1:0] req0_start_b,
  input  logic [W-1:0] req0_start_c,
  input  logic         EN_req0_start,
  output logic         RDY_req0_start,
  output logic [W-1:0] req0_result,
  output logic         RDY_req0_result,
  input  logic         EN_req0_result,
  output logic         req0_err,
  input  logic [W-1:0] req1_start_a,
  input  logic [W-1:0] req1_start_b,
  input  logic [W-1:0] req1_start_c,
  input  logic         EN_req1_start,
  output logic         RDY_req1_start,
  output logic [W-1:0] req1_result,
  output logic         RDY_req1_result,
  input  logic         EN_req1_result,
  output logic         req1_err,
  output logic [W-1:0] dsn_start_a,
  output logic [W-1:0] dsn_start_b,
  output logic         dsn_st_enable,
  input  logic         dsn_RDY_start,
  output logic [W-1:0] dsn_result_c,
  input  logic [W-1:0] dsn_result,
  input  logic         dsn_RDY_result
);

  arb_state_t   state_q, state_d;
  logic         owner_q, owner_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] c_q, c_d;
  logic [W-1:0] res_q, res_d;

  logic [1:0] grant;
  logic       st_idle, st_issue, st_wait, st_deliver;
  logic       accept, take_owner, tmo_hit, err_flag;

  assign st_idle    = (state_q == ST_IDLE);
  assign st_issue   = (state_q == ST_ISSUE);
  assign st_wait    = (state_q == ST_WAIT);
  assign st_deliver = (state_q == ST_DELIVER);

  assign accept     = st_idle & (|grant);
  assign take_owner = st_deliver & (owner_q ? EN_req1_result : EN_req0_result);

  arb_rr2 u_rr (
    .clk_i       (CLK),
    .rst_i       (RST),
    .req_i       ({EN_req1_start, EN_req0_start}),
    .upd_i       (take_owner),
    .upd_owner_i (owner_q),
    .grant_o     (grant)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Watchdog fires on the TMO-th busy cycle unless a result arrives that cycle.
  assign tmo_hit  = (st_issue | (st_wait & ~dsn_RDY_result)) & (cnt_q == CW'(TMO - 1));
  assign err_flag = err_q;

  // Busy-cycle counter and error flag, both restarted by each accepted start.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (accept) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (tmo_hit) begin
      err_d = 1'b1;
    end else if (st_issue | st_wait) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Watchdog state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(TMO);
  assign tmo_hit    = 1'b0;
  assign err_flag   = 1'b0;
`endif

  // Transaction sequencing and operand/result latching.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = grant[1];
          a_d     = grant[1] ? req1_start_a : req0_start_a;
          b_d     = grant[1] ? req1_start_b : req0_start_b;
          c_d     = grant[1] ? req1_start_c : req0_start_c;
          res_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (tmo_hit) begin
          state_d = ST_DELIVER;
        end else if (dsn_RDY_start) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dsn_RDY_result) begin
          res_d   = dsn_result;
          state_d = ST_DELIVER;
        end else if (tmo_hit) begin
          state_d = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        if (take_owner) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Main state register; reset abandons any transaction in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
    end
  end

  // Requester and design-side outputs; only the owner sees its result.
  always_comb begin
    RDY_req0_start  = st_idle & ~RST;
    RDY_req1_start  = st_idle & ~RST;
    dsn_st_enable   = st_issue & dsn_RDY_start & ~tmo_hit;
    dsn_start_a     = st_issue ? a_q : '0;
    dsn_start_b     = st_issue ? b_q : '0;
    dsn_result_c    = (st_issue | st_wait) ? c_q : '0;
    RDY_req0_result = st_deliver & ~owner_q;
    RDY_req1_result = st_deliver & owner_q;
    req0_result     = RDY_req0_result ? res_q : '0;
    req1_result     = RDY_req1_result ? res_q : '0;
    req0_err        = RDY_req0_result & err_flag;
    req1_err        = RDY_req1_result & err_flag;
  end

endmodule

// File: tb/tb_mk_design_arb_05.sv
// Directed bench for mk_design_arb_05: a cycle-by-cycle vector table for
// arbitration, the basic transaction and start backpressure, followed by
// hand sequences for reset, all-ones data and (with ARB_TIMEOUT_EN) timeout.
module tb_mk_design_arb_05;

  localparam int W = 9;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] r0a, r0b, r0c, r1a, r1b, r1c;
  logic         EN_req0_start = 1'b0, EN_req1_start = 1'b0;
  logic         EN_req0_result = 1'b0, EN_req1_result = 1'b0;
  logic         dsn_RDY_start = 1'b0, dsn_RDY_result = 1'b0;
  logic [W-1:0] dsn_result = '0;

  logic         RDY_req0_start, RDY_req1_start, RDY_req0_result, RDY_req1_result;
  logic [W-1:0] req0_result, req1_result;
  logic         req0_err, req1_err;
  logic [W-1:0] dsn_start_a, dsn_start_b, dsn_result_c;
  logic         dsn_st_enable;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  mk_design_arb_05 #(.W(W), .TMO(8)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .req0_start_a    (r0a),
    .req0_start_b    (r0b),
    .req0_start_c    (r0c),
    .EN_req0_start   (EN_req0_start),
    .RDY_req0_start  (RDY_req0_start),
    .req0_result     (req0_result),
    .RDY_req0_result (RDY_req0_result),
    .EN_req0_result  (EN_req0_result),
    .req0_err        (req0_err),
    .req1_start_a    (r1a),
    .req1_start_b    (r1b),
    .req1_start_c    (r1c),
    .EN_req1_start   (EN_req1_start),
    .RDY_req1_start  (RDY_req1_start),
    .req1_result     (req1_result),
    .RDY_req1_result (RDY_req1_result),
    .EN_req1_result  (EN_req1_result),
    .req1_err        (req1_err),
    .dsn_start_a     (dsn_start_a),
    .dsn_start_b     (dsn_start_b),
    .dsn_st_enable   (dsn_st_enable),
    .dsn_RDY_start   (dsn_RDY_start),
    .dsn_result_c    (dsn_result_c),
    .dsn_result      (dsn_result),
    .dsn_RDY_result  (dsn_RDY_result)
  );

  typedef struct {
    logic [1:0]   en_s;
    logic [1:0]   en_r;
    logic         rdy_st;
    logic         rdy_res;
    logic [W-1:0] dres;
    logic         x_rdy_start;
    logic         x_st_en;
    logic [1:0]   x_rdy_r;
    logic [W-1:0] x_res0;
    logic [W-1:0] x_res1;
    logic [W-1:0] x_a;
    logic [W-1:0] x_b;
    logic [W-1:0] x_c;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [1:0] en_s, input logic [1:0] en_r,
                             input logic rdy_st, input logic rdy_res, input logic [W-1:0] dres,
                             input logic x_rs, input logic x_st, input logic [1:0] x_rr,
                             input logic [W-1:0] x_r0, input logic [W-1:0] x_r1,
                             input logic [W-1:0] x_a, input logic [W-1:0] x_b,
                             input logic [W-1:0] x_c);
    vec_t t;
    t.en_s = en_s; t.en_r = en_r; t.rdy_st = rdy_st; t.rdy_res = rdy_res; t.dres = dres;
    t.x_rdy_start = x_rs; t.x_st_en = x_st; t.x_rdy_r = x_rr;
    t.x_res0 = x_r0; t.x_res1 = x_r1; t.x_a = x_a; t.x_b = x_b; t.x_c = x_c;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] es, input logic [1:0] er, input logic rs,
                       input logic rr, input logic [W-1:0] dr);
    EN_req0_start  = es[0];
    EN_req1_start  = es[1];
    EN_req0_result = er[0];
    EN_req1_result = er[1];
    dsn_RDY_start  = rs;
    dsn_RDY_result = rr;
    dsn_result     = dr;
  endtask

  task automatic apply(input vec_t t, input int idx);
    string p;
    @(posedge CLK); #1;
    drive(t.en_s, t.en_r, t.rdy_st, t.rdy_res, t.dres);
    @(negedge CLK);
    p = $sformatf("row%0d", idx);
    chk({p, ".rdy_start0"}, 32'(RDY_req0_start), 32'(t.x_rdy_start));
    chk({p, ".rdy_start1"}, 32'(RDY_req1_start), 32'(t.x_rdy_start));
    chk({p, ".st_enable"},  32'(dsn_st_enable),  32'(t.x_st_en));
    chk({p, ".rdy_result"}, 32'({RDY_req1_result, RDY_req0_result}), 32'(t.x_rdy_r));
    chk({p, ".res0"}, 32'(req0_result), 32'(t.x_res0));
    chk({p, ".res1"}, 32'(req1_result), 32'(t.x_res1));
    chk({p, ".dsn_a"}, 32'(dsn_start_a), 32'(t.x_a));
    chk({p, ".dsn_b"}, 32'(dsn_start_b), 32'(t.x_b));
    chk({p, ".dsn_c"}, 32'(dsn_result_c), 32'(t.x_c));
    chk({p, ".err"}, 32'({req1_err, req0_err}), 32'(0));
    $display("row %0d en_s=%b en_r=%b st_en=%b rdy_r=%b res0=%0h res1=%0h",
             idx, t.en_s, t.en_r, dsn_st_enable, {RDY_req1_result, RDY_req0_result},
             req0_result, req1_result);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    r0a = 9'd3;    r0b = 9'd5;    r0c = 9'd7;
    r1a = 9'h011;  r1b = 9'h022;  r1c = 9'h033;

    // Scenario A: simultaneous starts after reset, then retry ordering.
    tbl.push_back(v(2'b11, 2'b00, 1, 0, 9'h000, 1, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(v(2'b10, 2'b00, 1, 0, 9'h000, 0, 1, 2'b00, 0, 0, 3, 5, 7));
    tbl.push_back(v(2'b10, 2'b00, 1, 1, 9'h00A, 0, 0, 2'b00, 0, 0, 0, 0, 7));
    tbl.push_back(v(2'b10, 2'b00, 1, 0, 9'h000, 0, 0, 2'b01, 9'h00A, 0, 0, 0, 0));
    tbl.push_back(v(2'b10, 2'b01, 1, 0, 9'h000, 0, 0, 2'b01, 9'h00A, 0, 0, 0, 0));
    tbl.push_back(v(2'b11, 2'b00, 1, 0, 9'h000, 1, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(v(2'b00, 2'b00, 1, 0, 9'h000, 0, 1, 2'b00, 0, 0, 9'h011, 9'h022, 9'h033));
    tbl.push_back(v(2'b00, 2'b00, 1, 1, 9'h055, 0, 0, 2'b00, 0, 0, 0, 0, 9'h033));
    tbl.push_back(v(2'b00, 2'b01, 1, 0, 9'h000, 0, 0, 2'b10, 0, 9'h055, 0, 0, 0));
    tbl.push_back(v(2'b00, 2'b10, 1, 0, 9'h000, 0, 0, 2'b10, 0, 9'h055, 0, 0, 0));
    tbl.push_back(v(2'b00, 2'b00, 1, 0, 9'h000, 1, 0, 2'b00, 0, 0, 0, 0, 0));
    // Scenario B: single req0, result ready at cycle 3, delivered at cycle 4.
    tbl.push_back(v(2'b01, 2'b00, 1, 0, 9'h000, 1, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(v(2'b00, 2'b00, 1, 0, 9'h000, 0, 1, 2'b00, 0, 0, 3, 5, 7));
    tbl.push_back(v(2'b00, 2'b00, 1, 0, 9'h000, 0, 0, 2'b00, 0, 0, 0, 0, 7));
    tbl.push_back(v(2'b00, 2'b00, 1, 1, 9'h01F, 0, 0, 2'b00, 0, 0, 0, 0, 7));
    tbl.push_back(v(2'b00, 2'b00, 1, 0, 9'h000, 0, 0, 2'b01, 9'h01F, 0, 0, 0, 0));
    tbl.push_back(v(2'b00, 2'b01, 1, 0, 9'h000, 0, 0, 2'b01, 9'h01F, 0, 0, 0, 0));
    tbl.push_back(v(2'b00, 2'b00, 1, 0, 9'h000, 1, 0, 2'b00, 0, 0, 0, 0, 0));
    // Scenario C: req1 with dsn_RDY_start low for 4 ISSUE cycles.
    tbl.push_back(v(2'b10, 2'b00, 0, 0, 9'h000, 1, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(v(2'b00, 2'b00, 0, 0, 9'h000, 0, 0, 2'b00, 0, 0, 9'h011, 9'h022, 9'h033));
    tbl.push_back(v(2'b00, 2'b00, 0, 1, 9'h099, 0, 0, 2'b00, 0, 0, 9'h011, 9'h022, 9'h033));
    tbl.push_back(v(2'b00, 2'b00, 0, 0, 9'h000, 0, 0, 2'b00, 0, 0, 9'h011, 9'h022, 9'h033));
    tbl.push_back(v(2'b00, 2'b00, 0, 0, 9'h000, 0, 0, 2'b00, 0, 0, 9'h011, 9'h022, 9'h033));
    tbl.push_back(v(2'b00, 2'b00, 1, 0, 9'h000, 0, 1, 2'b00, 0, 0, 9'h011, 9'h022, 9'h033));
    tbl.push_back(v(2'b00, 2'b00, 1, 0, 9'h000, 0, 0, 2'b00, 0, 0, 0, 0, 9'h033));
    tbl.push_back(v(2'b00, 2'b00, 1, 1, 9'h1AB, 0, 0, 2'b00, 0, 0, 0, 0, 9'h033));
    tbl.push_back(v(2'b00, 2'b10, 1, 0, 9'h000, 0, 0, 2'b10, 0, 9'h1AB, 0, 0, 0));
    tbl.push_back(v(2'b00, 2'b00, 1, 0, 9'h000, 1, 0, 2'b00, 0, 0, 0, 0, 0));

    // Reset state: everything low while RST is held, ready after release.
    #2 RST = 1'b1;
    #1;
    chk("rst.rdy_start0", 32'(RDY_req0_start), 32'(0));
    chk("rst.rdy_start1", 32'(RDY_req1_start), 32'(0));
    chk("rst.outputs", 32'({dsn_st_enable, RDY_req0_result, RDY_req1_result, req0_err, req1_err}), 32'(0));
    chk("rst.dsn_c", 32'(dsn_result_c), 32'(0));
    #19 RST = 1'b0;
    @(negedge CLK);
    chk("rst.release_rdy", 32'({RDY_req1_start, RDY_req0_start}), 32'(2'b11));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // Reset in the middle of WAIT abandons the transaction.
    @(posedge CLK); #1 drive(2'b01, 2'b00, 1, 0, '0);
    @(posedge CLK); #1 drive(2'b00, 2'b00, 1, 0, '0);
    @(posedge CLK); #1 drive(2'b00, 2'b00, 1, 0, '0);
    #1;
    chk("midwait.dsn_c_before", 32'(dsn_result_c), 32'(7));
    #1 RST = 1'b1;
    #1;
    chk("midwait.dsn_c_in_rst", 32'(dsn_result_c), 32'(0));
    chk("midwait.rdy_start_in_rst", 32'(RDY_req0_start), 32'(0));
    @(negedge CLK); #2 RST = 1'b0;
    drive(2'b00, 2'b00, 1, 1, 9'h077);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("midwait.rdy_start", 32'({RDY_req1_start, RDY_req0_start}), 32'(2'b11));
      chk("midwait.no_result", 32'({RDY_req1_result, RDY_req0_result}), 32'(0));
      chk("midwait.no_fire", 32'(dsn_st_enable), 32'(0));
    end
    $display("seq reset-mid-wait done");

    // All-ones operands and an ignored non-owner result enable.
    r0a = 9'h1FF; r0b = 9'h1FF; r0c = 9'h1FF;
    @(posedge CLK); #1 drive(2'b01, 2'b00, 1, 0, '0);
    @(posedge CLK); #1 drive(2'b00, 2'b00, 1, 0, '0);
    @(negedge CLK);
    chk("ones.st_en", 32'(dsn_st_enable), 32'(1));
    chk("ones.dsn_a", 32'(dsn_start_a), 32'(9'h1FF));
    chk("ones.dsn_b", 32'(dsn_start_b), 32'(9'h1FF));
    chk("ones.dsn_c", 32'(dsn_result_c), 32'(9'h1FF));
    @(posedge CLK); #1 drive(2'b00, 2'b00, 1, 1, 9'h1FF);
    @(posedge CLK); #1 drive(2'b00, 2'b10, 1, 0, '0);
    @(negedge CLK);
    chk("ones.rdy_r", 32'({RDY_req1_result, RDY_req0_result}), 32'(2'b01));
    chk("ones.res0", 32'(req0_result), 32'(9'h1FF));
    @(posedge CLK); #1 drive(2'b00, 2'b01, 1, 0, '0);
    @(negedge CLK);
    chk("ones.nonowner_ignored", 32'({RDY_req1_result, RDY_req0_result}), 32'(2'b01));
    @(posedge CLK); #1 drive(2'b00, 2'b00, 1, 0, '0);
    @(negedge CLK);
    chk("ones.back_idle", 32'(RDY_req0_start), 32'(1));
    $display("seq all-ones done res0=%0h", req0_result);

`ifdef ARB_TIMEOUT_EN
    // Timeout with TMO=8: no result ever, owner gets err=1 and result 0.
    begin
      int lat;
      lat = -1;
      r0a = 9'd3; r0b = 9'd5; r0c = 9'd7;
      @(posedge CLK); #1 drive(2'b01, 2'b00, 1, 0, '0);
      for (int k = 1; k <= 30; k++) begin
        @(posedge CLK); #1 drive(2'b00, 2'b00, 1, 0, '0);
        @(negedge CLK);
        if (RDY_req0_result && lat < 0) lat = k;
        if (lat >= 0) break;
      end
      chk("tmo.latency", 32'(lat), 32'(9));
      chk("tmo.err0", 32'(req0_err), 32'(1));
      chk("tmo.res0", 32'(req0_result), 32'(0));
      chk("tmo.err1", 32'({RDY_req1_result, req1_err}), 32'(0));
      @(posedge CLK); #1 drive(2'b00, 2'b01, 1, 0, '0);
      @(posedge CLK); #1 drive(2'b00, 2'b00, 1, 0, '0);
      @(negedge CLK);
      chk("tmo.back_idle", 32'(RDY_req0_start), 32'(1));
      $display("seq timeout done latency=%0d", lat);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
